// File: rtl/kb_game_keys.sv
// PS/2 set-2 scan-code parser that tracks a configurable table of game keys.
// Emits held level, press/release pulses and a long-hold flag per key.
module kb_game_keys #(
    parameter int                        NUM_KEYS       = 5,
    parameter logic [8*NUM_KEYS-1:0]     KEY_CODES      = 40'h1D_1B_42_12_5A,
    parameter logic [NUM_KEYS-1:0]       EXT_MASK       = 5'b00000,
    parameter int                        HOLD_CYCLES    = 50_000_000,
    parameter int                        TIMEOUT_CYCLES = 100_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                code_valid,
    input  logic [7:0]          code,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic                busy
);

    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_MAX  = HCW'(HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_PRE  = HCW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]  GAP_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    function automatic logic is_filler(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: is_filler = 1'b1;
            default:                           is_filler = 1'b0;
        endcase
    endfunction

    logic [1:0]          rst_sync_r;
    logic                rst_n_s;
    state_t              state_r, state_next_s;
    logic [2:0]          pause_cnt_r, pause_cnt_next_s;
    logic [TW-1:0]       gap_r, gap_next_s;
    logic                make_s, brk_s, ext_s;
    logic [NUM_KEYS-1:0] match_s;
    logic [HCW-1:0]      hold_cnt_r [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_held_r, key_press_r, key_release_r, key_long_r;
    logic                busy_r;

    // Reset synchroniser: asserts asynchronously, releases after two clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_r <= 2'b00;
        else        rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
    assign rst_n_s = rst_sync_r[1];

    // Prefix parser next-state, Pause swallowing and gap timeout.
    always_comb begin
        state_next_s     = state_r;
        pause_cnt_next_s = pause_cnt_r;
        gap_next_s       = '0;
        make_s           = 1'b0;
        brk_s            = 1'b0;
        ext_s            = 1'b0;
        if (code_valid) begin
            if (state_r == ST_PAUSE) begin
                if (pause_cnt_r == 3'd6) begin
                    state_next_s     = ST_IDLE;
                    pause_cnt_next_s = 3'd0;
                end else begin
                    pause_cnt_next_s = pause_cnt_r + 3'd1;
                end
            end else if (code == 8'hE1) begin
                state_next_s     = ST_PAUSE;
                pause_cnt_next_s = 3'd0;
            end else if (is_filler(code)) begin
                state_next_s = state_r;
            end else if (code == 8'hE0) begin
                state_next_s = (state_r == ST_IDLE || state_r == ST_EXT) ? ST_EXT : ST_EXT_BRK;
            end else if (code == 8'hF0) begin
                state_next_s = (state_r == ST_IDLE || state_r == ST_BRK) ? ST_BRK : ST_EXT_BRK;
            end else begin
                state_next_s = ST_IDLE;
                ext_s        = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
                make_s       = (state_r == ST_IDLE) || (state_r == ST_EXT);
                brk_s        = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
            end
        end else if (state_r != ST_IDLE) begin
            // A strobe on the terminal cycle wins; only a silent gap expires.
            if (gap_r == GAP_LAST) begin
                state_next_s = ST_IDLE;
                gap_next_s   = '0;
            end else begin
                gap_next_s = gap_r + 1'b1;
            end
        end else begin
            gap_next_s = '0;
        end
    end

    // Key table match on the completed byte.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match_s[i] = (code == KEY_CODES[8*i +: 8]) && (ext_s == EXT_MASK[i]);
        end
    end

    // Parser state registers.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r     <= ST_IDLE;
            pause_cnt_r <= 3'd0;
            gap_r       <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pause_cnt_r <= pause_cnt_next_s;
            gap_r       <= gap_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Per-key held/pulse/long-hold tracking; typematic repeats keep counting.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            key_held_r    <= '0;
            key_press_r   <= '0;
            key_release_r <= '0;
            key_long_r    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) hold_cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_press_r[i]   <= 1'b0;
                key_release_r[i] <= 1'b0;
                if (brk_s && match_s[i] && key_held_r[i]) begin
                    key_held_r[i]    <= 1'b0;
                    key_release_r[i] <= 1'b1;
                    key_long_r[i]    <= 1'b0;
                    hold_cnt_r[i]    <= '0;
                end else if (make_s && match_s[i] && !key_held_r[i]) begin
                    key_held_r[i]  <= 1'b1;
                    key_press_r[i] <= 1'b1;
                    key_long_r[i]  <= 1'b0;
                    hold_cnt_r[i]  <= '0;
                end else if (key_held_r[i] && (hold_cnt_r[i] != HOLD_MAX)) begin
                    hold_cnt_r[i] <= hold_cnt_r[i] + 1'b1;
                    if (hold_cnt_r[i] == HOLD_PRE) key_long_r[i] <= 1'b1;
                    else                           key_long_r[i] <= key_long_r[i];
                end else begin
                    hold_cnt_r[i] <= hold_cnt_r[i];
                end
            end
        end
    end

    assign key_held    = key_held_r;
    assign key_press   = key_press_r;
    assign key_release = key_release_r;
    assign key_long    = key_long_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_kb_game_keys.sv
// Directed scoreboard bench for kb_game_keys: expectations are queued per step
// and popped when the DUT outputs are sampled one time unit after the clock edge.
module tb_kb_game_keys;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic [4:0] key_held, key_press, key_release, key_long;
    logic       busy;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    typedef struct {
        string      tag;
        logic [4:0] held;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] lng;
        logic       busy;
    } exp_t;
    exp_t sb[$];

    // key4=W(1D) key3=S(1B) key2=E0-14 (extended only) key1=Shift(12) key0=Enter(5A)
    kb_game_keys #(
        .NUM_KEYS(5),
        .KEY_CODES(40'h1D_1B_14_12_5A),
        .EXT_MASK(5'b00100),
        .HOLD_CYCLES(10),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .code_valid(code_valid),
        .code(code),
        .key_held(key_held),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic expect_state(input string tag, input logic [4:0] h, input logic [4:0] p,
                                input logic [4:0] r, input logic [4:0] l, input logic b);
        exp_t e;
        e.tag = tag; e.held = h; e.press = p; e.rel = r; e.lng = l; e.busy = b;
        sb.push_back(e);
    endtask

    task automatic compare_next();
        exp_t e;
        logic [20:0] obs, exv;
        checks++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: observed 0 entries expected at least 1");
        end else begin
            e   = sb.pop_front();
            obs = {key_held, key_press, key_release, key_long, busy};
            exv = {e.held, e.press, e.rel, e.lng, e.busy};
            assert (obs === exv) passed++;
            else begin
                fails++;
                $error("FAIL %s: observed held/press/rel/long/busy=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                       e.tag, obs[20:16], obs[15:11], obs[10:6], obs[5:1], obs[0],
                       exv[20:16], exv[15:11], exv[10:6], exv[5:1], exv[0]);
            end
        end
    endtask

    task automatic step(input logic [7:0] b, input string tag, input logic [4:0] h,
                        input logic [4:0] p, input logic [4:0] r, input logic [4:0] l,
                        input logic bz);
        expect_state(tag, h, p, r, l, bz);
        code       = b;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        compare_next();
    endtask

    task automatic idle(input string tag, input logic [4:0] h, input logic [4:0] p,
                        input logic [4:0] r, input logic [4:0] l, input logic bz);
        expect_state(tag, h, p, r, l, bz);
        @(posedge clk);
        #1;
        compare_next();
    endtask

    initial begin
        logic [7:0] pause_seq [7];
        pause_seq = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        expect_state("reset_state", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        compare_next();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // W press, typematic repeats, break
        step(8'h1D, "w_make",      5'b10000, 5'b10000, 5'b0, 5'b0, 1'b0);
        idle(       "w_pulse_end", 5'b10000, 5'b00000, 5'b0, 5'b0, 1'b0);
        step(8'h1D, "w_repeat1",   5'b10000, 5'b00000, 5'b0, 5'b0, 1'b0);
        step(8'h1D, "w_repeat2",   5'b10000, 5'b00000, 5'b0, 5'b0, 1'b0);
        step(8'hF0, "w_brk_pref",  5'b10000, 5'b00000, 5'b0, 5'b0, 1'b1);
        step(8'h1D, "w_break",     5'b00000, 5'b00000, 5'b10000, 5'b0, 1'b0);
        idle(       "w_rel_end",   5'b00000, 5'b00000, 5'b00000, 5'b0, 1'b0);

        // Extended-only key: plain 14 ignored, E0 14 make, E0 F0 14 break
        step(8'h14, "ext_plain",   5'b00000, 5'b00000, 5'b0, 5'b0, 1'b0);
        step(8'hE0, "ext_pref",    5'b00000, 5'b00000, 5'b0, 5'b0, 1'b1);
        step(8'h14, "ext_make",    5'b00100, 5'b00100, 5'b0, 5'b0, 1'b0);
        step(8'hE0, "ext_brk_e0",  5'b00100, 5'b00000, 5'b0, 5'b0, 1'b1);
        step(8'hF0, "ext_brk_f0",  5'b00100, 5'b00000, 5'b0, 5'b0, 1'b1);
        step(8'h14, "ext_break",   5'b00000, 5'b00000, 5'b00100, 5'b0, 1'b0);

        // Pause sequence swallowed: busy throughout, idle after 8th byte
        step(8'hE1, "pause_0", 5'b0, 5'b0, 5'b0, 5'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            step(pause_seq[k], $sformatf("pause_%0d", k + 1), 5'b0, 5'b0, 5'b0, 5'b0, (k < 6));
        end
        step(8'h12, "shift_make",  5'b00010, 5'b00010, 5'b0, 5'b0, 1'b0);
        step(8'hF0, "shift_pref",  5'b00010, 5'b00000, 5'b0, 5'b0, 1'b1);
        step(8'h12, "shift_break", 5'b00000, 5'b00000, 5'b00010, 5'b0, 1'b0);

        // Long hold after exactly 10 cycles, dropped together with held
        step(8'h5A, "enter_make", 5'b00001, 5'b00001, 5'b0, 5'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            idle($sformatf("long_%0d", k), 5'b00001, 5'b0, 5'b0,
                 (k >= 10) ? 5'b00001 : 5'b00000, 1'b0);
        end
        step(8'hF0, "enter_pref",  5'b00001, 5'b0, 5'b0, 5'b00001, 1'b1);
        step(8'h5A, "enter_break", 5'b00000, 5'b0, 5'b00001, 5'b00000, 1'b0);

        // Stale break prefix discarded after 20 idle cycles
        step(8'hF0, "to_pref", 5'b0, 5'b0, 5'b0, 5'b0, 1'b1);
        for (int k = 1; k <= 25; k++) begin
            idle($sformatf("to_gap_%0d", k), 5'b0, 5'b0, 5'b0, 5'b0, (k < 20));
        end
        step(8'h1B, "to_make", 5'b01000, 5'b01000, 5'b0, 5'b0, 1'b0);

        // Async reset mid-frame clears held keys and pending prefix, no pulses
        step(8'h1D, "w_make2", 5'b11000, 5'b10000, 5'b0, 5'b0, 1'b0);
        step(8'hE0, "mid_pref", 5'b11000, 5'b00000, 5'b0, 5'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        expect_state("async_clear", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        compare_next();
        idle("in_reset", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            idle($sformatf("post_reset_%0d", k), 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        end
        step(8'h1D, "w_after_reset", 5'b10000, 5'b10000, 5'b0, 5'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
